// File: rtl/image_loader.sv
// Frame de-framer for the MNIST byte stream: fills the back bank of a
// ping-pong pixel RAM, checks the 2-byte trailer and hands banks to the CNN engine.
module image_loader #(
    parameter int          IMAGE_SIZE = 784,
    parameter int          ADDR_W     = 10,
    parameter logic [7:0]  START_BYTE = 8'h66,
    parameter logic [7:0]  END1       = 8'h66,
    parameter logic [7:0]  END2       = 8'hBB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              engine_busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              image_start,
    output logic              image_valid,
    output logic              pending,
    output logic              frame_error,
    output logic              overrun,
    input  logic              clear_flags
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_TRL1,
        S_TRL2,
        S_RESYNC
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              seen_end1_q, seen_end1_d;
    logic              front_sel_q, front_sel_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              pending_q, pending_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        rd_data_q;

    logic [7:0] bank0_q [IMAGE_SIZE];
    logic [7:0] bank1_q [IMAGE_SIZE];

    logic we, swap_req, swap_now, ferr_set, ovr_set;

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        seen_end1_d = seen_end1_q;
        we          = 1'b0;
        swap_req    = 1'b0;
        ferr_set    = 1'b0;
        ovr_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_ready && rx_data == START_BYTE) begin
                    if (!pending_q) begin
                        state_d   = S_RECV;
                        wr_addr_d = '0;
                    end else begin
                        ovr_set     = 1'b1;
                        state_d     = S_RESYNC;
                        seen_end1_d = 1'b0;
                    end
                end
            end
            S_RECV: begin
                if (rx_ready) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == LAST_ADDR) state_d = S_TRL1;
                end
            end
            S_TRL1: begin
                if (rx_ready) begin
                    if (rx_data == END1) begin
                        state_d = S_TRL2;
                    end else begin
                        ferr_set    = 1'b1;
                        state_d     = S_RESYNC;
                        seen_end1_d = 1'b0;
                    end
                end
            end
            S_TRL2: begin
                if (rx_ready) begin
                    if (rx_data == END2) begin
                        state_d  = S_IDLE;
                        swap_req = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                        if (rx_data != END1) begin
                            state_d     = S_RESYNC;
                            seen_end1_d = 1'b0;
                        end
                    end
                end
            end
            S_RESYNC: begin
                // Mirror the router: only the END1,END2 pair ends its receive state.
                if (rx_ready) begin
                    if (seen_end1_q && rx_data == END2) state_d = S_IDLE;
                    seen_end1_d = (rx_data == END1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        swap_now    = !engine_busy && (swap_req || pending_q);
        pending_d   = pending_q;
        if (swap_req && engine_busy) pending_d = 1'b1;
        else if (swap_now)           pending_d = 1'b0;
        front_sel_d = front_sel_q ^ swap_now;
        start_d     = swap_now;
        valid_d     = valid_q | swap_now;
        // A same-cycle set beats clear_flags.
        ferr_d      = ferr_set | (ferr_q & !clear_flags);
        ovr_d       = ovr_set  | (ovr_q  & !clear_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            seen_end1_q <= 1'b0;
            front_sel_q <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            pending_q   <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            seen_end1_q <= seen_end1_d;
            front_sel_q <= front_sel_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            pending_q   <= pending_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            rd_data_q   <= front_sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
        end
    end

    // Writes always target the back bank; the front bank is read-only.
    always_ff @(posedge clk) begin
        if (we && front_sel_q)  bank0_q[wr_addr_q] <= rx_data;
        if (we && !front_sel_q) bank1_q[wr_addr_q] <= rx_data;
    end

    assign rd_data     = rd_data_q;
    assign image_start = start_q;
    assign image_valid = valid_q;
    assign pending     = pending_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader: a byte-level frame model predicts every
// output each cycle, plus literal checks of the directed scenarios.
module tb_image_loader;

    localparam int N = 784;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       engine_busy = 1'b0;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       image_start, image_valid, pending, frame_error, overrun;
    logic       clear_flags = 1'b0;

    image_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .engine_busy(engine_busy), .rd_addr(rd_addr), .rd_data(rd_data),
        .image_start(image_start), .image_valid(image_valid), .pending(pending),
        .frame_error(frame_error), .overrun(overrun), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte counter position in the frame plus two pixel arrays.
    logic [7:0] mbank [2][N];
    bit         mdef  [2][N];
    int         pos = -1;       // -1 waiting for start, 0..N-1 pixel, N/N+1 trailer, -2 resync
    bit         prev_end1 = 0;
    bit         mfront = 0, mvalid = 0, mpend = 0, mferr = 0, movr = 0, mstart = 0;
    logic [7:0] mrd = 8'h00;
    bit         mrd_known = 0;
    bit         mlive = 0;

    always @(posedge clk) begin
        bit req, sf, so, sw;
        if (rst) begin
            pos = -1; prev_end1 = 0; mfront = 0; mvalid = 0; mpend = 0;
            mferr = 0; movr = 0; mstart = 0; mrd = 8'h00; mrd_known = 1; mlive = 1;
        end else begin
            mrd_known = (rd_addr < N) && mdef[mfront][rd_addr];
            mrd = mrd_known ? mbank[mfront][rd_addr] : 8'h00;
            req = 0; sf = 0; so = 0;
            if (rx_ready) begin
                if (pos == -1) begin
                    if (rx_data == 8'h66) begin
                        if (mpend) begin so = 1; pos = -2; prev_end1 = 0; end
                        else pos = 0;
                    end
                end else if (pos >= 0 && pos < N) begin
                    mbank[mfront ? 0 : 1][pos] = rx_data;
                    mdef[mfront ? 0 : 1][pos] = 1;
                    pos++;
                end else if (pos == N) begin
                    if (rx_data == 8'h66) pos = N + 1;
                    else begin sf = 1; pos = -2; prev_end1 = 0; end
                end else if (pos == N + 1) begin
                    if (rx_data == 8'hBB) begin req = 1; pos = -1; end
                    else begin
                        sf = 1;
                        if (rx_data != 8'h66) begin pos = -2; prev_end1 = 0; end
                    end
                end else begin
                    if (prev_end1 && rx_data == 8'hBB) pos = -1;
                    prev_end1 = (rx_data == 8'h66);
                end
            end
            sw = !engine_busy && (req || mpend);
            if (req && engine_busy) mpend = 1;
            else if (sw) mpend = 0;
            if (sw) begin mfront = !mfront; mvalid = 1; end
            mstart = sw;
            mferr = sf | (mferr & !clear_flags);
            movr  = so | (movr & !clear_flags);
        end
    end

    always @(negedge clk) begin
        if (mlive) begin
            chk("image_start", image_start, mstart);
            chk("image_valid", image_valid, mvalid);
            chk("pending", pending, mpend);
            chk("frame_error", frame_error, mferr);
            chk("overrun", overrun, movr);
            if (mrd_known) chk("rd_data", rd_data, mrd);
        end
    end

    int nstart = 0;
    always @(posedge clk) if (image_start === 1'b1) nstart++;

    bit       rd_force = 0;
    int       rd_force_addr = 0;
    always @(negedge clk) rd_addr = rd_force ? 10'(rd_force_addr) : 10'($urandom_range(0, N - 1));

    logic [7:0] pix [N];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data = 8'($urandom);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) send_byte(pix[i]);
    endtask

    task automatic send_frame();
        send_byte(8'h66); send_pixels(N); send_byte(8'h66); send_byte(8'hBB);
    endtask

    task automatic rand_pix();
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
    endtask

    task automatic read_at(input int a, input logic [7:0] exp, input string name);
        rd_force = 1; rd_force_addr = a;
        idle(3);
        chk(name, rd_data, exp);
        rd_force = 0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1; @(negedge clk); clear_flags = 1'b0;
    endtask

    initial begin
        int s0;
        logic [7:0] old0, first0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("reset image_valid", image_valid, 0);
        chk("reset image_start", image_start, 0);
        chk("reset pending", pending, 0);
        chk("reset rd_data", rd_data, 8'h00);
        rst = 1'b0;

        // Nominal frame
        for (int i = 0; i < N; i++) pix[i] = 8'(i);
        send_frame(); idle(3);
        chk("nominal starts", nstart, 1);
        chk("nominal image_valid", image_valid, 1);
        read_at(0, 8'h00, "nominal px0");
        read_at(255, 8'hFF, "nominal px255");
        read_at(783, 8'h0F, "nominal px783");

        // Binary-safe payload full of marker bytes
        for (int i = 0; i < N; i++) pix[i] = (i % 2 == 0) ? 8'h66 : 8'hBB;
        send_frame(); idle(3);
        chk("binsafe starts", nstart, 2);
        read_at(0, 8'h66, "binsafe px0");
        read_at(783, 8'hBB, "binsafe px783");

        // Bad trailer, then a good frame
        rand_pix(); s0 = nstart;
        send_byte(8'h66); send_pixels(N);
        send_byte(8'h12); send_byte(8'h66); send_byte(8'hBB); idle(2);
        chk("badtrl frame_error", frame_error, 1);
        chk("badtrl no start", nstart, s0);
        read_at(1, 8'hBB, "badtrl front kept");
        pulse_clear(); idle(1);
        chk("badtrl cleared", frame_error, 0);
        rand_pix(); send_frame(); idle(2);
        chk("after bad good start", nstart, s0 + 1);
        read_at(5, pix[5], "after bad px5");
        old0 = pix[0];

        // Deferred swap and overrun while pending
        engine_busy = 1'b1; rand_pix(); first0 = pix[0]; s0 = nstart;
        send_frame(); idle(4);
        chk("deferred pending", pending, 1);
        chk("deferred no start", nstart, s0);
        read_at(0, old0, "deferred old front");
        rand_pix(); send_frame(); idle(2);
        chk("overrun set", overrun, 1);
        chk("overrun no start", nstart, s0);
        engine_busy = 1'b0; idle(3);
        chk("deferred single start", nstart, s0 + 1);
        chk("deferred pending clr", pending, 0);
        read_at(0, first0, "deferred new px0");
        pulse_clear(); idle(1);
        chk("overrun cleared", overrun, 0);

        // Reset in the middle of a frame
        rand_pix(); send_byte(8'h66); send_pixels(400);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        rand_pix(); send_frame(); idle(2);
        chk("post-reset valid", image_valid, 1);
        read_at(0, pix[0], "post-reset px0");

        // Random traffic with busy toggling and occasional corrupt trailers
        for (int f = 0; f < 6; f++) begin
            int kind;
            rand_pix();
            engine_busy = ($urandom_range(0, 2) == 0);
            kind = $urandom_range(0, 3);
            send_byte(8'h66);
            send_pixels(N);
            if (kind == 0) begin
                send_byte(8'h66); send_byte(8'h66); send_byte(8'hBB);
            end else if (kind == 1) begin
                send_byte(8'($urandom)); send_byte(8'h66); send_byte(8'hBB);
            end else begin
                send_byte(8'h66); send_byte(8'hBB);
            end
            idle($urandom_range(1, 5));
            engine_busy = 1'b0;
            idle(3);
            if ($urandom_range(0, 1) == 0) pulse_clear();
        end
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_loader.md
# image_loader

Downstream consumer of the UART router's image byte stream. It strips the framing, writes the 784 pixel bytes of one MNIST frame into a ping-pong (double-buffered) image RAM, and validates the trailer. It then hands the completed bank to the CNN engine through a registered read port and a start pulse. This lets the next image stream in while the engine is still reading the previous one.

## Interface
- IMAGE_SIZE, 784: pixel bytes per frame.
- ADDR_W, 10: pixel address width; must satisfy 2^ADDR_W >= IMAGE_SIZE.
- START_BYTE, 8'h66: first forwarded byte; marks frame start.
- END1, 8'h66 / END2, 8'hBB: two-byte trailer expected after IMAGE_SIZE pixels.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  byte from the router image channel.
- rx_ready  in  1  one-cycle strobe; rx_data is valid.
- engine_busy  in  1  CNN engine is reading the front bank.
- rd_addr  in  ADDR_W  engine pixel address (0..IMAGE_SIZE-1).
- rd_data  out  8  front-bank pixel, registered.
- image_start  out  1  one-cycle pulse: new front bank is ready.
- image_valid  out  1  front bank holds a complete frame; set at the first swap, then held.
- pending  out  1  a completed frame waits in the back bank.
- frame_error  out  1  sticky: trailer mismatch.
- overrun  out  1  sticky: a frame was dropped because a swap was pending.
- clear_flags  in  1  one-cycle pulse; clears frame_error and overrun.

## Operation
- Storage: two banks of IMAGE_SIZE x 8. front_sel selects the read bank; writes always go to the other bank.
- States: IDLE, RECV, TRL1, TRL2, RESYNC.
- IDLE
  - rx_ready with rx_data == START_BYTE and pending == 0: go to RECV, wr_addr = 0.
  - rx_ready with START_BYTE and pending == 1: set overrun, go to RESYNC (frame dropped).
  - Any other byte: ignored.
- RECV
  - Each rx_ready writes rx_data to back[wr_addr], then wr_addr++.
  - After the write at wr_addr == IMAGE_SIZE-1: go to TRL1.
  - Bytes equal to the marker values are stored as data (binary safe).
- TRL1: on rx_ready, rx_data == END1 goes to TRL2. Otherwise set frame_error and go to RESYNC.
- TRL2
  - On rx_ready with rx_data == END2: frame complete, go to IDLE and raise the swap request.
  - Otherwise set frame_error. If rx_data == END1, stay in TRL2. Else go to RESYNC.
- RESYNC: consume bytes until END1 is followed immediately by END2, then go to IDLE. This tracks the router, which only leaves its receive state on that pair. No writes occur in RESYNC.
- Swap
  - If engine_busy == 0 when the swap is requested: toggle front_sel, pulse image_start, set image_valid.
  - Otherwise set pending. At the first cycle with pending == 1 and engine_busy == 0: swap, pulse image_start, clear pending.
- The front bank is never written.
- clear_flags has priority below a same-cycle flag set: a set wins.

## Timing
- Reset values: state = IDLE, front_sel = 0, wr_addr = 0, rd_data = 0, image_start = 0, image_valid = 0, pending = 0, frame_error = 0, overrun = 0. RAM contents are not cleared.
- rd_data = front[rd_addr], one cycle latency. A read in the same cycle as a swap returns the old front bank.
- RAM write occurs at the edge where rx_ready is sampled.
- Swap request when the END2 strobe is at edge T:
  - engine_busy sampled low at T: front_sel toggles and image_start = 1 during T+1; image_valid is high from T+1.
  - engine_busy sampled high at T: pending = 1 from T+1.
  - Deferred swap: engine_busy sampled low at edge E with pending = 1 gives image_start during E+1, pending low from E+1.
- image_start is never high for two consecutive cycles.
- Reset mid-frame: the partial frame is abandoned. The next frame needs a fresh START_BYTE.

## Test plan
- Nominal frame: 0x66, pixels p[i] = i & 0xFF (784 bytes), 0x66, 0xBB, engine_busy = 0.
  - Required: image_start pulses once, image_valid = 1.
  - Reading addr 0, 255, 783 returns 0x00, 0xFF, 0x0F one cycle later.
- Binary safety: frame whose pixels are all 0x66/0xBB alternating. Required: all 784 stored correctly, no early exit, a single image_start.
- Bad trailer: 784 pixels, then 0x12, 0x66, 0xBB.
  - Required: frame_error = 1, no image_start, state returns to IDLE.
  - A following good frame then loads normally.
- Deferred swap: frame completes with engine_busy = 1. Required: pending = 1, rd_data still shows the old frame. Drop engine_busy: image_start next cycle, new data readable.
- Overrun: while pending = 1, send a second full frame. Required: overrun = 1, back bank unchanged, single swap after engine_busy falls. clear_flags resets overrun.
- Reset at pixel 400, then a full frame: only the second frame is presented, pixel 0 equals its first pixel.
